// File: rtl/response_generator.sv
// Single-outstanding request engine: pops a request packet, performs one
// memory read or write, and returns the matching AXI R or B response.
module response_generator #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 16,
    parameter int INDEX_BIT_SIZE = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // request FIFO
    input  logic                      fifo_empty_i,
    output logic                      fifo_read_en_o,
    input  logic [127:0]              fifo_data_i,
    // memory
    output logic [INDEX_BIT_SIZE-1:0] mem_index_o,
    output logic                      mem_rd_en_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      mem_wr_en_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    // AXI W
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    // AXI R
    output logic [ID_WIDTH-1:0]       rid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    // AXI B
    output logic [ID_WIDTH-1:0]       bid_o,
    output logic [1:0]                bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_RD,
        S_RWAIT,
        S_RRESP,
        S_WDATA,
        S_BRESP
    } state_t;

    state_t                    state;
    logic [ID_WIDTH-1:0]       id_q;
    logic                      dec_err_q;

    // Packet fields, meaningful only while in S_POP
    logic                      pkt_rw;
    logic [ID_WIDTH-1:0]       pkt_id;
    logic [ADDR_WIDTH-1:0]     pkt_addr;
    logic                      pkt_err;
    logic                      unused_bits;

    assign pkt_rw      = fifo_data_i[0];
    assign pkt_id      = fifo_data_i[ID_WIDTH:1];
    assign pkt_addr    = fifo_data_i[ADDR_WIDTH+ID_WIDTH:ID_WIDTH+1];
    assign pkt_err     = |pkt_addr[ADDR_WIDTH-1:INDEX_BIT_SIZE];
    assign unused_bits = ^fifo_data_i[127:ADDR_WIDTH+ID_WIDTH+1];

    // Pop strobe and write-beat forwarding must act in the same cycle as
    // their inputs, so these are decoded from the state register directly.
    assign fifo_read_en_o = (state == S_IDLE) && !fifo_empty_i;
    assign mem_wr_en_o    = (state == S_WDATA) && wvalid_i && !dec_err_q;
    assign mem_wdata_o    = (state == S_WDATA) ? wdata_i : '0;

    // Request sequencing with registered response/strobe outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            id_q        <= '0;
            dec_err_q   <= 1'b0;
            mem_index_o <= '0;
            mem_rd_en_o <= 1'b0;
            wready_o    <= 1'b0;
            rvalid_o    <= 1'b0;
            rid_o       <= '0;
            rdata_o     <= '0;
            rresp_o     <= '0;
            rlast_o     <= 1'b0;
            bvalid_o    <= 1'b0;
            bid_o       <= '0;
            bresp_o     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!fifo_empty_i) state <= S_POP;
                end
                S_POP: begin
                    id_q        <= pkt_id;
                    dec_err_q   <= pkt_err;
                    mem_index_o <= pkt_addr[INDEX_BIT_SIZE-1:0];
                    if (pkt_rw) begin
                        wready_o <= 1'b1;
                        state    <= S_WDATA;
                    end else if (pkt_err) begin
                        // Errored read skips memory; response loads straight from the packet
                        rvalid_o <= 1'b1;
                        rid_o    <= pkt_id;
                        rdata_o  <= '0;
                        rresp_o  <= RESP_DECERR;
                        rlast_o  <= 1'b1;
                        state    <= S_RRESP;
                    end else begin
                        mem_rd_en_o <= 1'b1;
                        state       <= S_RD;
                    end
                end
                S_RD: begin
                    mem_rd_en_o <= 1'b0;
                    state       <= S_RWAIT;
                end
                S_RWAIT: begin
                    rvalid_o <= 1'b1;
                    rid_o    <= id_q;
                    rdata_o  <= mem_rdata_i;
                    rresp_o  <= RESP_OKAY;
                    rlast_o  <= 1'b1;
                    state    <= S_RRESP;
                end
                S_RRESP: begin
                    if (rready_i) begin
                        rvalid_o <= 1'b0;
                        rlast_o  <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_WDATA: begin
                    if (wvalid_i) begin
                        wready_o <= 1'b0;
                        bvalid_o <= 1'b1;
                        bid_o    <= id_q;
                        bresp_o  <= dec_err_q ? RESP_DECERR : RESP_OKAY;
                        state    <= S_BRESP;
                    end
                end
                S_BRESP: begin
                    if (bready_i) begin
                        bvalid_o <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
